timer_prog_m: RTL and testbench

TIMER_PROG_M -- requirements
Module: timer_prog_m

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_ch_m.sv | 106 ++++++++++
 rtl/timer_prog_m.sv | 59 +++++
 tb/tb_timer_prog_m.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer: channel state encoding,
// mode constants, default parameter values and the per-channel control bundle.
package timer_pkg;

  // Default parameter values for timer_prog_m
  localparam int NCH_DEF     = 4;
  localparam int PRE_DIV_DEF = 50;
  localparam int CNT_W_DEF   = 16;

  // Channel mode encoding as seen on ch_oneshot_i
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Per-channel control inputs, grouped so the top can fan them out per lane
  typedef struct packed {
    logic en;
    logic oneshot;
    logic start;
  } ch_ctrl_t;

endpackage

// File: rtl/timer_ch_m.sv
// One timer channel: IDLE/RUN FSM, base-tick counter, shadow period,
// registered expiry pulse and square output. Counts base ticks from the
// shared prescaler only.
module timer_ch_m
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             base_tick_i,
  input  ch_ctrl_t         ctrl_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic             busy_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;

  logic period_ok;
  logic expire;
  logic retrig;

  assign period_ok = (period_i != '0);
  // Shadow is never zero while in RUN, so shadow-1 cannot underflow there.
  assign expire    = base_tick_i && (cnt_q == shadow_q - CNT_W'(1));
  // Retrigger is judged on the latched mode; a zero period makes it a no-op.
  assign retrig    = (mode_q == MODE_ONESHOT) && ctrl_i.start && period_ok;

  // Next-state and datapath: IDLE arms on enable/start, RUN counts and wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    sq_d     = sq_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sq_d  = 1'b0;
        if (ctrl_i.en && period_ok &&
            (ctrl_i.oneshot == MODE_PERIODIC || ctrl_i.start)) begin
          state_d  = ST_RUN;
          shadow_d = period_i;
          mode_d   = ctrl_i.oneshot;
        end
      end
      ST_RUN: begin
        if (!ctrl_i.en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sq_d    = 1'b0;
        end else if (retrig) begin
          // Start beats a coincident expiry: no tick, period restarts.
          cnt_d    = '0;
          shadow_d = period_i;
        end else if (expire) begin
          tick_d   = 1'b1;
          cnt_d    = '0;
          shadow_d = period_i;
          mode_d   = ctrl_i.oneshot;
          if (mode_q == MODE_ONESHOT || !period_ok) begin
            state_d = ST_IDLE;
            sq_d    = 1'b0;
          end else begin
            sq_d = ~sq_q;
          end
        end else if (base_tick_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      mode_q   <= MODE_PERIODIC;
      tick_q   <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign busy_o = (state_q == ST_RUN);

endmodule

// File: rtl/timer_prog_m.sv
// Programmable multi-channel timer: one shared prescaler producing a base
// tick every PRE_DIV clocks, and NCH independent channels counting it.
module timer_prog_m
  import timer_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int PRE_DIV = PRE_DIV_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       ch_en_i,
  input  logic [NCH-1:0]       ch_oneshot_i,
  input  logic [NCH-1:0]       ch_start_i,
  input  logic [NCH*CNT_W-1:0] ch_period_i,
  output logic                 base_tick_o,
  output logic [NCH-1:0]       ch_tick_o,
  output logic [NCH-1:0]       ch_sq_o,
  output logic [NCH-1:0]       ch_busy_o
);

  localparam int PW = $clog2(PRE_DIV);

  logic [PW-1:0] pre_cnt_q;
  logic          base_q;
  logic          pre_last;

  assign pre_last = (pre_cnt_q == PW'(PRE_DIV - 1));

  // Prescaler: 0..PRE_DIV-1, registered strobe the cycle after the top count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      base_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_last ? '0 : pre_cnt_q + PW'(1);
      base_q    <= pre_last;
    end
  end

  assign base_tick_o = base_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    ch_ctrl_t ctrl;
    assign ctrl = '{en: ch_en_i[k], oneshot: ch_oneshot_i[k], start: ch_start_i[k]};

    timer_ch_m #(.CNT_W(CNT_W)) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .base_tick_i (base_q),
      .ctrl_i      (ctrl),
      .period_i    (ch_period_i[k*CNT_W +: CNT_W]),
      .tick_o      (ch_tick_o[k]),
      .sq_o        (ch_sq_o[k]),
      .busy_o      (ch_busy_o[k])
    );
  end

endmodule

// File: tb/tb_timer_prog_m.sv
// Directed bench for timer_prog_m (NCH=4, PRE_DIV=50, CNT_W=16).
module tb_timer_prog_m;
  localparam int NCH = 4, PRE_DIV = 50, CNT_W = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NCH-1:0]       ch_en_i, ch_oneshot_i, ch_start_i;
  logic [NCH*CNT_W-1:0] ch_period_i;
  logic                 base_tick_o;
  logic [NCH-1:0]       ch_tick_o, ch_sq_o, ch_busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  timer_prog_m #(.NCH(NCH), .PRE_DIV(PRE_DIV), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_en_i(ch_en_i), .ch_oneshot_i(ch_oneshot_i),
    .ch_start_i(ch_start_i), .ch_period_i(ch_period_i), .base_tick_o(base_tick_o),
    .ch_tick_o(ch_tick_o), .ch_sq_o(ch_sq_o), .ch_busy_o(ch_busy_o)
  );

  // Clocks from now until ch_tick_o[ch] is seen high; -1 on timeout.
  task automatic wait_tick(input int ch, input int lim, output int dt);
    dt = 0;
    do begin @(negedge clk_i); dt++; end
    while (ch_tick_o[ch] !== 1'b1 && dt < lim);
    if (ch_tick_o[ch] !== 1'b1) dt = -1;
  endtask

  task automatic align_base();
    int n = 0;
    do begin @(negedge clk_i); n++; end while (base_tick_o !== 1'b1 && n < 200);
  endtask

  task automatic set_period(input int ch, input int v);
    ch_period_i[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic pulse_start(input int ch);
    ch_start_i[ch] = 1'b1;
    @(negedge clk_i);
    ch_start_i[ch] = 1'b0;
  endtask

  task automatic test_reset();
    int pos[3];
    int nh = 0, stray = 0;
    pos = '{-1, -1, -1};
    rst_i = 1'b1; ch_en_i = '0; ch_oneshot_i = '0; ch_start_i = '0; ch_period_i = '0;
    repeat (3) @(negedge clk_i);
    total++;
    if ({base_tick_o, ch_tick_o, ch_sq_o, ch_busy_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", {base_tick_o, ch_tick_o, ch_sq_o, ch_busy_o});
    end
    rst_i = 1'b0;
    for (int i = 1; i <= 160; i++) begin
      @(negedge clk_i);
      if (base_tick_o === 1'b1) begin
        if (nh < 3) pos[nh] = i;
        nh++;
      end
      if ({ch_tick_o, ch_sq_o, ch_busy_o} !== '0) stray++;
    end
    total++; if (nh != 3)     begin bad++; $display("FAIL base_tick_count got %0d want 3", nh); end
    total++; if (pos[0] != 50)  begin bad++; $display("FAIL base_tick_1 got %0d want 50", pos[0]); end
    total++; if (pos[1] != 100) begin bad++; $display("FAIL base_tick_2 got %0d want 100", pos[1]); end
    total++; if (pos[2] != 150) begin bad++; $display("FAIL base_tick_3 got %0d want 150", pos[2]); end
    total++; if (stray != 0)  begin bad++; $display("FAIL idle_ch_outputs got %0d want 0", stray); end
  endtask

  task automatic test_periodic();
    int dt;
    set_period(0, 3); ch_oneshot_i[0] = 1'b0; ch_en_i[0] = 1'b1;
    @(negedge clk_i);
    total++; if (ch_busy_o[0] !== 1'b1) begin bad++; $display("FAIL per_busy_entry got %b want 1", ch_busy_o[0]); end
    wait_tick(0, 400, dt);
    total++; if (dt <= 0) begin bad++; $display("FAIL per_first_tick got %0d want >0", dt); end
    total++; if (ch_sq_o[0] !== 1'b1) begin bad++; $display("FAIL per_sq_1 got %b want 1", ch_sq_o[0]); end
    wait_tick(0, 400, dt);
    total++; if (dt != 150) begin bad++; $display("FAIL per_interval_1 got %0d want 150", dt); end
    total++; if (ch_sq_o[0] !== 1'b0) begin bad++; $display("FAIL per_sq_2 got %b want 0", ch_sq_o[0]); end
    wait_tick(0, 400, dt);
    total++; if (dt != 150) begin bad++; $display("FAIL per_interval_2 got %0d want 150", dt); end
    total++; if ({ch_sq_o[0], ch_busy_o[0]} !== 2'b11) begin bad++; $display("FAIL per_sq_busy got %b want 11", {ch_sq_o[0], ch_busy_o[0]}); end
    ch_en_i[0] = 1'b0;
    @(negedge clk_i);
    total++; if ({ch_sq_o[0], ch_busy_o[0]} !== 2'b00) begin bad++; $display("FAIL per_disable got %b want 00", {ch_sq_o[0], ch_busy_o[0]}); end
  endtask

  task automatic test_oneshot();
    int dt, n;
    set_period(1, 2); ch_oneshot_i[1] = 1'b1; ch_en_i[1] = 1'b1;
    @(negedge clk_i);
    total++; if (ch_busy_o[1] !== 1'b0) begin bad++; $display("FAIL os_no_start got %b want 0", ch_busy_o[1]); end
    align_base();
    pulse_start(1);
    total++; if (ch_busy_o[1] !== 1'b1) begin bad++; $display("FAIL os_busy got %b want 1", ch_busy_o[1]); end
    wait_tick(1, 300, dt);
    total++; if (dt != 100) begin bad++; $display("FAIL os_latency got %0d want 100", dt); end
    total++; if (ch_busy_o[1] !== 1'b0) begin bad++; $display("FAIL os_busy_at_tick got %b want 0", ch_busy_o[1]); end
    n = 0;
    repeat (300) begin @(negedge clk_i); if (ch_tick_o[1] === 1'b1 || ch_busy_o[1] === 1'b1) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL os_quiet got %0d want 0", n); end
    ch_en_i[1] = 1'b0;
  endtask

  task automatic test_retrigger();
    int dt, n;
    set_period(2, 4); ch_oneshot_i[2] = 1'b1; ch_en_i[2] = 1'b1;
    align_base();
    pulse_start(2);
    repeat (3) align_base();
    pulse_start(2);
    wait_tick(2, 400, dt);
    total++; if (dt != 200) begin bad++; $display("FAIL retrig_latency got %0d want 200", dt); end
    n = 0;
    repeat (300) begin @(negedge clk_i); if (ch_tick_o[2] === 1'b1) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL retrig_extra_ticks got %0d want 0", n); end
    ch_en_i[2] = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_start_at_expiry();
    int dt;
    set_period(2, 1); ch_oneshot_i[2] = 1'b1; ch_en_i[2] = 1'b1;
    align_base();
    pulse_start(2);
    align_base();
    pulse_start(2);
    total++; if ({ch_tick_o[2], ch_busy_o[2]} !== 2'b01) begin bad++; $display("FAIL start_wins got %b want 01", {ch_tick_o[2], ch_busy_o[2]}); end
    wait_tick(2, 200, dt);
    total++; if (dt != 50) begin bad++; $display("FAIL start_wins_latency got %0d want 50", dt); end
    ch_en_i[2] = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_period_change();
    int dt, n;
    set_period(3, 4); ch_oneshot_i[3] = 1'b0; ch_en_i[3] = 1'b1;
    wait_tick(3, 500, dt);
    total++; if (dt <= 0) begin bad++; $display("FAIL chg_first_tick got %0d want >0", dt); end
    repeat (100) @(negedge clk_i);
    set_period(3, 2);
    wait_tick(3, 300, dt);
    total++; if (dt != 100) begin bad++; $display("FAIL chg_current got %0d want 100", dt); end
    wait_tick(3, 300, dt);
    total++; if (dt != 100) begin bad++; $display("FAIL chg_next_1 got %0d want 100", dt); end
    wait_tick(3, 300, dt);
    total++; if (dt != 100) begin bad++; $display("FAIL chg_next_2 got %0d want 100", dt); end
    ch_en_i[3] = 1'b0; set_period(3, 0);
    @(negedge clk_i);
    ch_en_i[3] = 1'b1;
    n = 0;
    repeat (200) begin @(negedge clk_i); if (ch_busy_o[3] === 1'b1 || ch_tick_o[3] === 1'b1) n++; end
    total++; if (n != 0) begin bad++; $display("FAIL zero_period_busy got %0d want 0", n); end
    ch_en_i[3] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    set_period(0, 3); ch_oneshot_i[0] = 1'b0; ch_en_i[0] = 1'b1;
    repeat (120) @(negedge clk_i);
    total++; if (ch_busy_o[0] !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", ch_busy_o[0]); end
    rst_i = 1'b1;
    @(negedge clk_i);
    total++; if ({base_tick_o, ch_tick_o, ch_sq_o, ch_busy_o} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs got %h want 0", {base_tick_o, ch_tick_o, ch_sq_o, ch_busy_o});
    end
    repeat (3) @(negedge clk_i);
    total++; if (ch_busy_o !== '0) begin bad++; $display("FAIL reset_overrides got %b want 0", ch_busy_o); end
    rst_i = 1'b0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (base_tick_o !== 1'b1 && n < 200);
    total++; if (n != 50) begin bad++; $display("FAIL post_reset_base got %0d want 50", n); end
    ch_en_i[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_retrigger();
    test_start_at_expiry();
    test_period_change();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
